// File: rtl/washing_machine_param.sv
// Parametrised washing machine controller.
// Runs a coin-started cycle: FILL -> (WASH -> RINSE) x reps -> SPIN -> IDLE.
// Phase lengths are PHASE_MIN*TICKS_PER_MIN scaled by 1/2/4/8 from clk_freq.
// An abort in any active phase drains the drum and returns to IDLE.
// Optional build macro WM_PAUSE_ALL_EN: timer_pause freezes the phase timer in
// FILL/WASH/RINSE/SPIN instead of SPIN only.
module washing_machine_param #(
  parameter int TICKS_PER_MIN = 60,
  parameter int FILL_MIN      = 2,
  parameter int WASH_MIN      = 5,
  parameter int RINSE_MIN     = 2,
  parameter int SPIN_MIN      = 1,
  parameter int DRAIN_MIN     = 1,
  parameter int REP_W         = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic [REP_W-1:0] wash_reps,
  input  logic             timer_pause,
  input  logic             abort,
  output logic             wash_done,
  output logic             aborted,
  output logic [2:0]       state,
  output logic [REP_W-1:0] rep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FILL  = 3'b001,
    S_WASH  = 3'b011,
    S_RINSE = 3'b010,
    S_SPIN  = 3'b110,
    S_DRAIN = 3'b100
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REP_W-1:0] tgt_q;
  logic [REP_W-1:0] rep_q;
  logic             done_q;
  logic             abrt_q;

  logic [CNT_W-1:0] base_len;
  logic [CNT_W-1:0] len;
  logic [REP_W-1:0] rep_inc;
  logic             phase_end;
  logic             paused;

  // Current phase length; recomputed every cycle so a clk_freq change takes effect mid-phase.
  always_comb begin
    base_len = '0;
    case (state_q)
      S_FILL:  base_len = CNT_W'(FILL_MIN  * TICKS_PER_MIN);
      S_WASH:  base_len = CNT_W'(WASH_MIN  * TICKS_PER_MIN);
      S_RINSE: base_len = CNT_W'(RINSE_MIN * TICKS_PER_MIN);
      S_SPIN:  base_len = CNT_W'(SPIN_MIN  * TICKS_PER_MIN);
      S_DRAIN: base_len = CNT_W'(DRAIN_MIN * TICKS_PER_MIN);
      default: base_len = '0;
    endcase
    len = base_len << clk_freq;
  end

  // >= rather than == so a shortened phase ends on the next unpaused edge.
  assign phase_end = (cnt_q >= len - CNT_W'(1));
  assign rep_inc   = rep_q + REP_W'(1);

`ifdef WM_PAUSE_ALL_EN
  assign paused = timer_pause && (state_q inside {S_FILL, S_WASH, S_RINSE, S_SPIN});
`else
  assign paused = timer_pause && (state_q == S_SPIN);
`endif

  // Cycle sequencer: abort beats pause beats phase completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      rep_q   <= '0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (coin_in) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            tgt_q   <= (wash_reps == '0) ? REP_W'(1) : wash_reps;
            rep_q   <= '0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
          end
        end
        S_FILL, S_WASH, S_RINSE, S_SPIN: begin
          if (abort) begin
            state_q <= S_DRAIN;
            cnt_q   <= '0;
            abrt_q  <= 1'b1;
          end else if (!paused) begin
            if (phase_end) begin
              cnt_q <= '0;
              case (state_q)
                S_FILL:  state_q <= S_WASH;
                S_WASH:  state_q <= S_RINSE;
                S_RINSE: begin
                  rep_q   <= rep_inc;
                  state_q <= (rep_inc < tgt_q) ? S_WASH : S_SPIN;
                end
                default: begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                end
              endcase
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (phase_end) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign wash_done = done_q;
  assign aborted   = abrt_q;
  assign rep_cnt   = rep_q;

endmodule

// File: tb/tb_washing_machine_param.sv
// Self-checking bench for washing_machine_param: directed phase-timing scenarios
// plus a randomized run against a phase-level reference model.
module tb_washing_machine_param;
  localparam int TPM   = 60;
  localparam int FILLM = 2, WASHM = 5, RINSEM = 2, SPINM = 1, DRAINM = 1;
  localparam int REP_W = 2, CNT_W = 32;
  localparam logic [2:0] C_IDLE = 3'b000, C_FILL = 3'b001, C_WASH = 3'b011,
                         C_RINSE = 3'b010, C_SPIN = 3'b110, C_DRAIN = 3'b100;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       clk_freq = 2'd0;
  logic             coin_in = 1'b0;
  logic [REP_W-1:0] wash_reps = '0;
  logic             timer_pause = 1'b0;
  logic             abort = 1'b0;
  logic             wash_done, aborted;
  logic [2:0]       state;
  logic [REP_W-1:0] rep_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase name, cycles elapsed in phase, pass bookkeeping
  logic [2:0] m_st = C_IDLE;
  int         m_el = 0, m_tgt = 0, m_rep = 0;
  logic       m_done = 1'b0, m_ab = 1'b0;

  washing_machine_param #(
    .TICKS_PER_MIN(TPM), .FILL_MIN(FILLM), .WASH_MIN(WASHM), .RINSE_MIN(RINSEM),
    .SPIN_MIN(SPINM), .DRAIN_MIN(DRAINM), .REP_W(REP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clk_freq(clk_freq), .coin_in(coin_in),
    .wash_reps(wash_reps), .timer_pause(timer_pause), .abort(abort),
    .wash_done(wash_done), .aborted(aborted), .state(state), .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  function automatic int phase_len(input logic [2:0] ph, input logic [1:0] f);
    int mins;
    case (ph)
      C_FILL:  mins = FILLM;
      C_WASH:  mins = WASHM;
      C_RINSE: mins = RINSEM;
      C_SPIN:  mins = SPINM;
      C_DRAIN: mins = DRAINM;
      default: mins = 0;
    endcase
    return (mins * TPM) << f;
  endfunction

  // Advance the reference model by one edge using the inputs about to be sampled.
  task automatic model_step();
    bit pause_hit;
`ifdef WM_PAUSE_ALL_EN
    pause_hit = timer_pause && (m_st != C_DRAIN);
`else
    pause_hit = timer_pause && (m_st == C_SPIN);
`endif
    if (rst) begin
      m_st = C_IDLE; m_el = 0; m_rep = 0; m_tgt = 0; m_done = 0; m_ab = 0;
    end else if (m_st == C_IDLE) begin
      if (coin_in) begin
        m_st = C_FILL; m_el = 0; m_rep = 0; m_done = 0; m_ab = 0;
        m_tgt = (int'(wash_reps) == 0) ? 1 : int'(wash_reps);
      end
    end else if (m_st == C_DRAIN) begin
      if (m_el + 1 >= phase_len(m_st, clk_freq)) begin m_st = C_IDLE; m_el = 0; end
      else m_el++;
    end else if (abort) begin
      m_st = C_DRAIN; m_el = 0; m_ab = 1;
    end else if (!pause_hit) begin
      if (m_el + 1 >= phase_len(m_st, clk_freq)) begin
        m_el = 0;
        if (m_st == C_FILL) m_st = C_WASH;
        else if (m_st == C_WASH) m_st = C_RINSE;
        else if (m_st == C_RINSE) begin
          m_rep++;
          m_st = (m_rep < m_tgt) ? C_WASH : C_SPIN;
        end else begin
          m_st = C_IDLE; m_done = 1;
        end
      end else m_el++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; coin_in = 0; abort = 0; timer_pause = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [1:0] f, input logic [REP_W-1:0] reps);
    clk_freq = f; wash_reps = reps; coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
  endtask

  // Check we are in phase exp, then count edges until the state changes.
  task automatic measure(input string nm, input logic [2:0] exp, input int exp_len);
    int n = 0;
    n_cmp++;
    if (state !== exp) begin
      n_bad++; $display("FAIL %s entry: state=%b required=%b", nm, state, exp);
    end
    while (state === exp && n < 20000) begin tick(); n++; end
    n_cmp++;
    if (n !== exp_len) begin
      n_bad++; $display("FAIL %s length: got %0d cycles required %0d", nm, n, exp_len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; coin_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (state !== C_IDLE || wash_done !== 1'b0) begin
        n_bad++; $display("FAIL reset_hold: state=%b done=%b required 000/0", state, wash_done);
      end
    end
    rst = 1'b0; wash_reps = 2'd1; clk_freq = 2'd0;
    tick();
    coin_in = 1'b0;
    n_cmp++;
    if (state !== C_FILL) begin
      n_bad++; $display("FAIL reset_release: state=%b required 001", state);
    end
  endtask

  task automatic test_single_pass();
    measure("sp_fill", C_FILL, 120);
    measure("sp_wash", C_WASH, 300);
    measure("sp_rinse", C_RINSE, 120);
    measure("sp_spin", C_SPIN, 60);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (state !== C_IDLE || wash_done !== 1'b1 || rep_cnt !== 2'd1) begin
        n_bad++;
        $display("FAIL sp_done_hold: state=%b done=%b rep=%0d required 000/1/1", state, wash_done, rep_cnt);
      end
      tick();
    end
    coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
    n_cmp++;
    if (state !== C_FILL || wash_done !== 1'b0) begin
      n_bad++; $display("FAIL sp_coin_clear: state=%b done=%b required 001/0", state, wash_done);
    end
  endtask

  task automatic test_repeats();
    do_reset();
    start(2'd3, 2'd3);
    measure("rp_fill", C_FILL, 960);
    for (int i = 1; i <= 3; i++) begin
      measure("rp_wash", C_WASH, 2400);
      measure("rp_rinse", C_RINSE, 960);
      n_cmp++;
      if (rep_cnt !== REP_W'(i)) begin
        n_bad++; $display("FAIL rp_repcnt: got %0d required %0d", rep_cnt, i);
      end
    end
    measure("rp_spin", C_SPIN, 480);
    n_cmp++;
    if (state !== C_IDLE || wash_done !== 1'b1) begin
      n_bad++; $display("FAIL rp_end: state=%b done=%b required 000/1", state, wash_done);
    end
    // zero repetitions behaves as one
    start(2'd0, 2'd0);
    measure("r0_fill", C_FILL, 120);
    measure("r0_wash", C_WASH, 300);
    measure("r0_rinse", C_RINSE, 120);
    n_cmp++;
    if (state !== C_SPIN || rep_cnt !== 2'd1) begin
      n_bad++; $display("FAIL r0_to_spin: state=%b rep=%0d required 110/1", state, rep_cnt);
    end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    start(2'd0, 2'd1);
    measure("ps_fill", C_FILL, 120);
    measure("ps_wash", C_WASH, 300);
    measure("ps_rinse", C_RINSE, 120);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; end
    timer_pause = 1'b1;
    for (int i = 0; i < 200; i++) begin tick(); n++; end
    timer_pause = 1'b0;
    while (state === C_SPIN && n < 20000) begin tick(); n++; end
    n_cmp++;
    if (n !== 260) begin
      n_bad++; $display("FAIL pause_spin: got %0d cycles required 260", n);
    end
    start(2'd0, 2'd1);
    measure("pw_fill", C_FILL, 120);
    n = 0;
    for (int i = 0; i < 50; i++) begin tick(); n++; end
    timer_pause = 1'b1;
    for (int i = 0; i < 200; i++) begin tick(); n++; end
    timer_pause = 1'b0;
    while (state === C_WASH && n < 20000) begin tick(); n++; end
    n_cmp++;
`ifdef WM_PAUSE_ALL_EN
    if (n !== 500) begin
      n_bad++; $display("FAIL pause_wash: got %0d cycles required 500", n);
    end
`else
    if (n !== 300) begin
      n_bad++; $display("FAIL pause_wash: got %0d cycles required 300", n);
    end
`endif
  endtask

  task automatic test_abort();
    do_reset();
    start(2'd0, 2'd1);
    measure("ab_fill", C_FILL, 120);
    for (int i = 0; i < 50; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (state !== C_DRAIN || aborted !== 1'b1) begin
      n_bad++; $display("FAIL ab_enter: state=%b aborted=%b required 100/1", state, aborted);
    end
    measure("ab_drain", C_DRAIN, 60);
    n_cmp++;
    if (state !== C_IDLE || wash_done !== 1'b0 || aborted !== 1'b1) begin
      n_bad++; $display("FAIL ab_idle: state=%b done=%b ab=%b required 000/0/1", state, wash_done, aborted);
    end
    // abort on the last RINSE cycle wins over the move to SPIN
    start(2'd0, 2'd1);
    measure("al_fill", C_FILL, 120);
    measure("al_wash", C_WASH, 300);
    for (int i = 0; i < 119; i++) tick();
    n_cmp++;
    if (state !== C_RINSE) begin
      n_bad++; $display("FAIL al_pre: state=%b required 010", state);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (state !== C_DRAIN) begin
      n_bad++; $display("FAIL al_last_rinse: state=%b required 100", state);
    end
    measure("al_drain", C_DRAIN, 60);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b0;
    n_cmp++;
    if (state !== C_IDLE || aborted !== 1'b1 || wash_done !== 1'b0) begin
      n_bad++; $display("FAIL ab_in_idle: state=%b ab=%b done=%b required 000/1/0", state, aborted, wash_done);
    end
  endtask

  task automatic test_freq_change();
    do_reset();
    start(2'd3, 2'd1);
    for (int i = 0; i < 500; i++) tick();
    n_cmp++;
    if (state !== C_FILL) begin
      n_bad++; $display("FAIL fc_pre: state=%b required 001", state);
    end
    clk_freq = 2'd0;
    tick();
    n_cmp++;
    if (state !== C_WASH) begin
      n_bad++; $display("FAIL fc_end: state=%b required 011", state);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      coin_in     = ($urandom % 6) == 0;
      timer_pause = ($urandom % 3) == 0;
      abort       = ($urandom % 300) == 0;
      wash_reps   = REP_W'($urandom);
      if (($urandom % 400) == 0) clk_freq = 2'($urandom_range(0, 1));
      rst         = ($urandom % 2500) == 0;
      tick();
      n_cmp++;
      if ({state, wash_done, aborted, rep_cnt} !== {m_st, m_done, m_ab, REP_W'(m_rep)}) begin
        n_bad++;
        if (errs < 20)
          $display("FAIL rand cyc %0d: st/done/ab/rep=%b/%b/%b/%0d required %b/%b/%b/%0d",
                   i, state, wash_done, aborted, rep_cnt, m_st, m_done, m_ab, m_rep);
        errs++;
      end
    end
    rst = 0; coin_in = 0; timer_pause = 0; abort = 0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_repeats();
    test_pause();
    test_abort();
    test_freq_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/washing_machine_param.md
Name: washing_machine_param

Overview:
- Parametrised successor to the fixed-cycle washing machine controller.
- Runs a coin-started sequence: FILL -> WASH/RINSE loop (runtime-selectable repetitions) -> SPIN -> IDLE.
- Phase durations are parameters, scaled by the clk_freq select; adds abort-with-drain and status outputs.
- Sits at top level, driven directly by board inputs.

Parameters:
- TICKS_PER_MIN, 60, clock cycles per minute at 1 MHz (scaled-down time base).
- FILL_MIN, 2, fill phase length in minutes.
- WASH_MIN, 5, wash phase length in minutes.
- RINSE_MIN, 2, rinse phase length in minutes.
- SPIN_MIN, 1, spin phase length in minutes.
- DRAIN_MIN, 1, drain phase length after abort, in minutes.
- REP_W, 2, width of the repetition request and counter.
- CNT_W, 32, phase counter width; must hold max(MIN)*TICKS_PER_MIN*8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clk_freq  in  2  00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz; phase length multiplier 1/2/4/8.
- coin_in  in  1  start request, level-sampled in IDLE.
- wash_reps  in  REP_W  number of wash+rinse passes; 0 treated as 1; latched at start.
- timer_pause  in  1  freezes phase timer (SPIN only, unless the optional feature is enabled).
- abort  in  1  cancel the cycle and drain.
- wash_done  out  1  cycle completed normally.
- aborted  out  1  last cycle was aborted.
- state  out  3  current state encoding.
- rep_cnt  out  REP_W  completed wash+rinse passes in the current cycle.

Behaviour:
- Single clock; all registers update on the rising edge of clk. rst is synchronous and active-high.
- On rst: state=IDLE, counter=0, rep_cnt=0, wash_done=0, aborted=0.
- State encodings: IDLE=000, FILL=001, WASH=011, RINSE=010, SPIN=110, DRAIN=100. Unused codes go to IDLE on the next edge.
- Phase length: len = PHASE_MIN*TICKS_PER_MIN << clk_freq, computed at CNT_W bits.
- Timing:
  - Counter clears on phase entry and increments each cycle that is not paused.
  - When counter >= len-1 and not paused, the state advances at that edge and the counter clears.
  - A phase therefore lasts exactly len cycles; example: FILL at 1 MHz = 120 cycles.
  - Using >= means a mid-phase clk_freq decrease ends the phase on the next unpaused edge.
- IDLE:
  - coin_in=1 at an edge -> FILL.
  - Same edge: latch max(wash_reps,1) as target, rep_cnt=0, wash_done=0, aborted=0.
  - coin_in is ignored in every non-IDLE state.
- Transitions:
  - FILL done -> WASH.
  - WASH done -> RINSE.
  - RINSE done: rep_cnt+1; if the new rep_cnt < target -> WASH, else -> SPIN.
  - SPIN done -> IDLE with wash_done=1.
- wash_done stays 1 until the next accepted coin; it clears on the same edge the coin moves the machine to FILL.
- Pause (default build):
  - timer_pause=1 in SPIN holds the counter; state is unchanged.
  - timer_pause is ignored in FILL/WASH/RINSE/DRAIN/IDLE.
- Abort:
  - abort=1 in FILL/WASH/RINSE/SPIN -> DRAIN; counter=0, aborted=1, wash_done stays 0.
  - Abort takes priority over phase completion and pause on the same edge.
  - abort is ignored in IDLE and DRAIN.
  - DRAIN done -> IDLE; aborted stays 1 until the next accepted coin.
- rep_cnt saturates at target and holds its value in IDLE until the next start.
- rst mid-phase: IDLE on the next edge and all outputs cleared, regardless of other inputs.

Optional Feature:
- Macro: WM_PAUSE_ALL_EN.
- Defined: timer_pause freezes the counter in FILL, WASH, RINSE and SPIN; DRAIN is never paused; abort still overrides pause.
- Undefined: pause acts in SPIN only, as described in Behaviour.

Test Plan:
- Reset and coin: rst=1 with coin_in=1 for 3 cycles -> state=000, wash_done=0. Release rst -> state=001 one edge later.
- Single pass at clk_freq=00, wash_reps=1:
  - FILL lasts 120 cycles, WASH 300, RINSE 120, SPIN 60.
  - Then state=000 and wash_done=1; wash_done holds through 5 idle cycles and clears on the edge coin_in=1 is accepted.
- Repeats at clk_freq=11, wash_reps=3:
  - FILL 960 cycles, then WASH 2400 / RINSE 960 three times, with rep_cnt stepping 1,2,3.
  - Then SPIN 480 -> IDLE.
  - Separate run with wash_reps=0 behaves as wash_reps=1.
- Pause:
  - timer_pause=1 for 200 cycles mid-SPIN at 1 MHz -> SPIN lasts 260 cycles.
  - timer_pause=1 during WASH -> WASH still lasts 300 cycles (default build).
  - With WM_PAUSE_ALL_EN defined, the same WASH pause extends WASH to 500 cycles.
- Abort:
  - abort at WASH cycle 50 -> state=100 next edge, aborted=1; DRAIN lasts 60 cycles, then IDLE with wash_done=0.
  - abort coinciding with the last RINSE cycle -> DRAIN, not SPIN.
  - abort in IDLE -> no change.
- Frequency change: switch clk_freq 11->00 at FILL cycle 500 -> FILL ends at the next edge (500 >= 119).
